sdram_read_fifo: RTL and testbench

- Buffer directly downstream of the SDRAM read engine.
- Absorbs its 32-bit FIFO writes (fifo_data/fifo_wr) and returns fifo_full as back-pressure.
- Presents the data to the host side as a 16-bit valid/ready stream: upper half-word first, then lower.
- Single clock domain, shared with the SDRAM controller.

---
 rtl/sdram_read_fifo.sv | 152 +++++++++++++++
 tb/tb_sdram_read_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read_fifo.sv
// sdram_read_fifo
//   Buffer directly downstream of the SDRAM read engine. It takes 32-bit words
//   from the engine's FIFO write port and returns back-pressure through full.
//   On the host side it presents the data as a 16-bit valid/ready stream,
//   upper half-word first and lower half-word second. Everything runs in the
//   SDRAM clock domain.
//
// Parameters
//   DEPTH_LOG2  log2 of the RAM capacity in 32-bit words (default 4 -> 16 words)
//   AF_MARGIN   almost_full asserts when count >= DEPTH - AF_MARGIN (1..DEPTH-1)
//
// Ports
//   clk          system/SDRAM clock, rising edge
//   rst          synchronous reset, active low
//   wr_en        write strobe (read engine fifo_wr)
//   wr_data      write word, [31:16] is delivered first
//   full         RAM holds DEPTH words (read engine fifo_full)
//   almost_full  count >= DEPTH - AF_MARGIN
//   flush        synchronous clear of all contents
//   out_data     current half-word
//   out_valid    out_data is valid
//   out_ready    consumer accepts out_data when out_valid & out_ready
//   count        words held in RAM; the output holding register is not counted
//
// Optional feature (macro SDRAM_READ_FIFO_STATS_EN)
//   overflow     sticky flag, set by any wr_en while full
//   drop_count   number of dropped writes, saturates at 16'hFFFF
//   Both outputs clear on reset and on flush.

module sdram_read_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  flush,
  output logic [15:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef SDRAM_READ_FIFO_STATS_EN
  output logic                  overflow,
  output logic [15:0]           drop_count,
`endif
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                 DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_LEVEL = (DEPTH_LOG2+1)'(DEPTH - AF_MARGIN);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt_p0;

  logic [31:0]           word_p1;
  logic                  half_p1;
  logic                  vld_p1;

  logic                  clear;
  logic                  push;
  logic                  last_accept;
  logic                  load;

  // Pointers only move when the count allows it, so full/empty come from the
  // count register alone and never from a pointer comparison.
  assign full        = (cnt_p0 == DEPTH_C);
  assign almost_full = (cnt_p0 >= AF_LEVEL);
  assign count       = cnt_p0;

  assign clear       = ~rst | flush;
  // Acceptance uses the registered full, so a pop in the same cycle cannot
  // make room for a write that arrives while full.
  assign push        = wr_en & ~full & ~clear;
  // Accepting the lower half empties the holding register; reloading on that
  // same edge keeps back-to-back words free of bubbles.
  assign last_accept = vld_p1 & out_ready & half_p1;
  assign load        = (cnt_p0 != '0) & (~vld_p1 | last_accept) & ~clear;

  assign out_data  = half_p1 ? word_p1[15:0] : word_p1[31:16];
  assign out_valid = vld_p1;

  // ---- stage p0: RAM write side and occupancy ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_p0 <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (load) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, load})
        2'b10:   cnt_p0 <= cnt_p0 + CNT_ONE;
        2'b01:   cnt_p0 <= cnt_p0 - CNT_ONE;
        default: cnt_p0 <= cnt_p0;
      endcase
    end
  end

  // ---- stage p1: 32-bit holding register and half-word select ----
  always_ff @(posedge clk) begin
    if (clear) begin
      word_p1 <= '0;
      half_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (load) begin
      word_p1 <= mem[rd_ptr];
      half_p1 <= 1'b0;
      vld_p1  <= 1'b1;
    end else if (vld_p1 && out_ready) begin
      if (!half_p1) begin
        half_p1 <= 1'b1;
      end else begin
        half_p1 <= 1'b0;
        vld_p1  <= 1'b0;
      end
    end
  end

`ifdef SDRAM_READ_FIFO_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (wr_en && full) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc16(drop_count);
    end
  end
`endif

endmodule

// File: tb/tb_sdram_read_fifo.sv
module tb_sdram_read_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        almost_full;
  logic        flush;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  count;
`ifdef SDRAM_READ_FIFO_STATS_EN
  logic        overflow;
  logic [15:0] drop_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int pop_count = 0;
  logic [15:0] exp_q[$];

  sdram_read_fifo #(.DEPTH_LOG2(4), .AF_MARGIN(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .flush       (flush),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef SDRAM_READ_FIFO_STATS_EN
    .overflow    (overflow),
    .drop_count  (drop_count),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] w);
    exp_q.push_back(w[31:16]);
    exp_q.push_back(w[15:0]);
  endtask

  // Scoreboard: every handshake pops the oldest expected half-word.
  always @(negedge clk) begin
    if (rst && !flush && out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed %0h expected none", out_data);
      end
      if (exp_q.size() != 0) begin
        check("sb_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
      pop_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic seen;
    logic [15:0] prev_d;
    logic prev_v, prev_r;

    // Reset held for two edges with a write pending.
    rst = 1'b0; wr_en = 1'b1; wr_data = 32'h1234_5678; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b1; wr_en = 1'b0;
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_data", out_data, 16'h0000);
    step();
    check("rst_count_after", count, 0);

    // Single word, one-cycle latency, upper then lower.
    out_ready = 1'b1;
    wr_en = 1'b1; wr_data = 32'hDEAD_BEEF; push_exp(32'hDEAD_BEEF);
    step();
    wr_en = 1'b0;
    check("single_lat_valid", out_valid, 0);
    check("single_lat_count", count, 1);
    step();
    check("single_valid_hi", out_valid, 1);
    check("single_data_hi", out_data, 16'hDEAD);
    step();
    check("single_valid_lo", out_valid, 1);
    check("single_data_lo", out_data, 16'hBEEF);
    step();
    check("single_valid_end", out_valid, 0);
    check("single_sb_empty", exp_q.size(), 0);

    // Fill with the consumer stalled; the first word sits in the holding register.
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      wr_en = 1'b1; wr_data = 32'(k); push_exp(32'(k));
      step();
      check("fill_count", count, (k == 0) ? 1 : k);
      check("fill_afull", almost_full, ((k == 0 ? 1 : k) >= 14) ? 1 : 0);
      check("fill_full", full, (k == 16) ? 1 : 0);
    end
    wr_en = 1'b1; wr_data = 32'hFFFF_FFFF;
    step();
    wr_en = 1'b0;
    check("drop_count_stays", count, 16);
    check("drop_full", full, 1);
    check("drop_hold_valid", out_valid, 1);
    check("drop_hold_data", out_data, 16'h0000);
`ifdef SDRAM_READ_FIFO_STATS_EN
    check("stats_overflow_set", overflow, 1);
    check("stats_drop_count", drop_count, 1);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    check("drain_done", exp_q.size(), 0);
    check("drain_valid_end", out_valid, 0);
    check("drain_count_end", count, 0);
    check("drain_full_end", full, 0);

    // Continuous stream: one word every other cycle, consumer always ready.
    start = pop_count;
    seen = 1'b0;
    for (int c = 0; c < 86; c++) begin
      wr_en = (c % 2 == 0) && (c < 80);
      wr_data = 32'hA000_5000 + 32'(c / 2) * 32'h0001_0001;
      if (wr_en) push_exp(wr_data);
      step();
      check("stream_cnt_le2", (count <= 2) ? 1 : 0, 1);
      if (out_valid) seen = 1'b1;
      if (seen && (pop_count - start) < 80) check("stream_no_bubble", out_valid, 1);
    end
    wr_en = 1'b0;
    check("stream_pops", pop_count - start, 80);
    check("stream_sb_empty", exp_q.size(), 0);

    // Consumer toggling ready every cycle.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_data = 32'hC0DE_0100 + 32'(k) * 32'h0001_0001;
      push_exp(wr_data);
      step();
    end
    wr_en = 1'b0;
    start = pop_count;
    for (int c = 0; c < 14; c++) begin
      out_ready = (c % 2 == 0);
      prev_d = out_data; prev_v = out_valid; prev_r = out_ready;
      step();
      if (!prev_r && prev_v) begin
        check("toggle_hold_data", out_data, prev_d);
        check("toggle_hold_valid", out_valid, 1);
      end
    end
    check("toggle_pops", pop_count - start, 6);
    check("toggle_sb_empty", exp_q.size(), 0);

    // Flush with five words stored, lower half showing and a write pending.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1; wr_data = {16'hF0A0 + 16'(k), 16'h0B00 + 16'(k)};
      push_exp(wr_data);
      step();
    end
    wr_en = 1'b0;
    check("pre_flush_count", count, 5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pre_flush_lower", out_data, 16'h0B00);
    check("pre_flush_valid", out_valid, 1);
`ifdef SDRAM_READ_FIFO_STATS_EN
    check("pre_flush_overflow", overflow, 1);
`endif
    flush = 1'b1; wr_en = 1'b1; wr_data = 32'hBAD0_BAD0;
    exp_q.delete();
    step();
    flush = 1'b0; wr_en = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_full", full, 0);
`ifdef SDRAM_READ_FIFO_STATS_EN
    check("flush_overflow", overflow, 0);
    check("flush_drop_count", drop_count, 0);
`endif
    out_ready = 1'b1;
    step(); step();
    check("flush_write_absent", out_valid, 0);
    check("flush_write_absent_cnt", count, 0);
    wr_en = 1'b1; wr_data = 32'h1357_2468; push_exp(wr_data);
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    check("post_flush_sb_empty", exp_q.size(), 0);
    step();
    check("post_flush_valid_end", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
